// File: rtl/toeplitz_seq_if.sv
// Stream-in, hash-out and seed-arbitration signals of the Toeplitz sequencer.
// master: stimulus/consumer side; slave: the sequencer.
interface toeplitz_seq_if #(
   parameter int W = 64,
   parameter int L = 128
) ();
   logic [W-1:0] s_data;
   logic         s_valid;
   logic         s_ready;
   logic [L-1:0] m_data;
   logic         m_valid;
   logic         m_ready;
   logic         seed_req;
   logic         seed_gnt;

   modport master (
      output s_data, s_valid, m_ready, seed_req,
      input  s_ready, m_data, m_valid, seed_gnt
   );

   modport slave (
      input  s_data, s_valid, m_ready, seed_req,
      output s_ready, m_data, m_valid, seed_gnt
   );
endinterface

// File: rtl/toeplitz_seq.sv
// Toeplitz hash sequencer: gathers one N-bit block, restarts the column
// generator bank, walks N columns STRIDE per cycle while XOR-accumulating
// the columns of set bits, then presents the L-bit hash on a valid/ready port.

// One lane: gates its generator column by the block bit it owns this cycle.
module toeplitz_lane #(
   parameter int L = 128
) (
   input  logic         bit_i,
   input  logic [L-1:0] col_i,
   output logic [L-1:0] term_o
);
   assign term_o = bit_i ? col_i : '0;
endmodule

module toeplitz_seq #(
   parameter int N      = 256,
   parameter int L      = 128,
   parameter int STRIDE = 1,
   parameter int W      = 64
) (
   input  logic                clk,
   input  logic                reset,
   toeplitz_seq_if.slave       bus,
   output logic                gen_reset,
   input  logic [STRIDE*L-1:0] gen_col,
   output logic                busy,
   output logic [15:0]         blk_cnt
);
   localparam int NBEAT = N / W;
   localparam int NCOL  = N / STRIDE;
   localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
   localparam int KW    = $clog2(NCOL) + 1;

   localparam logic [BW-1:0] BEAT_LAST = BW'(NBEAT - 1);
   localparam logic [KW-1:0] K_LAST    = KW'(NCOL - 1);

   typedef enum logic [1:0] {S_FILL, S_PRIME, S_RUN, S_OUT} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [N-1:0]    buf_q, buf_d;
   logic [L-1:0]    acc_q, acc_d;
   logic [KW-1:0]   k_q, k_d;
   logic [15:0]     blk_q, blk_d;

   logic            s_ready_c, gnt_c, gen_reset_c, busy_c, m_valid_c;
   logic            accept;
   logic [N-1:0]    fill_shift;
   logic [L-1:0]    col_xor;
   logic [STRIDE-1:0][L-1:0] term;

   // Beats shift in from the top so beat 0 ends up in the low W bits.
   generate
      if (N == W) begin : g_one_beat
         assign fill_shift = bus.s_data;
      end else begin : g_multi_beat
         assign fill_shift = {bus.s_data, buf_q[N-1:W]};
      end
   endgenerate

   // During RUN the buffer shifts down by STRIDE, so lane g always sees bit g.
   generate
      for (genvar g = 0; g < STRIDE; g++) begin : g_lane
         toeplitz_lane #(.L(L)) u_lane (
            .bit_i  (buf_q[g]),
            .col_i  (gen_col[g*L +: L]),
            .term_o (term[g])
         );
      end
   endgenerate

   // GF(2) sum of this cycle's selected columns.
   always_comb begin
      col_xor = '0;
      for (int i = 0; i < STRIDE; i++) col_xor = col_xor ^ term[i];
   end

   assign accept = s_ready_c & bus.s_valid;

   // Next-state and control outputs; seed grant wins over data at beat 0.
   always_comb begin
      state_d     = state_q;
      s_ready_c   = 1'b0;
      gnt_c       = 1'b0;
      gen_reset_c = 1'b0;
      busy_c      = 1'b0;
      m_valid_c   = 1'b0;
      case (state_q)
         S_FILL: begin
            gnt_c     = (beat_q == '0) && bus.seed_req;
            s_ready_c = ~gnt_c;
            if (accept && beat_q == BEAT_LAST) state_d = S_PRIME;
         end
         S_PRIME: begin
            gen_reset_c = 1'b1;
            busy_c      = 1'b1;
            state_d     = S_RUN;
         end
         S_RUN: begin
            busy_c = 1'b1;
            if (k_q == K_LAST) state_d = S_OUT;
         end
         S_OUT: begin
            busy_c    = 1'b1;
            m_valid_c = 1'b1;
            if (bus.m_ready) state_d = S_FILL;
         end
         default: state_d = S_FILL;
      endcase
   end

   // Datapath next-state: beat capture, column walk and block counting.
   always_comb begin
      beat_d = beat_q;
      buf_d  = buf_q;
      acc_d  = acc_q;
      k_d    = k_q;
      blk_d  = blk_q;
      case (state_q)
         S_FILL: begin
            if (accept) begin
               buf_d  = fill_shift;
               beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
            end
         end
         S_PRIME: begin
            acc_d = '0;
            k_d   = '0;
         end
         S_RUN: begin
            acc_d = acc_q ^ col_xor;
            k_d   = k_q + 1'b1;
            buf_d = buf_q >> STRIDE;
         end
         S_OUT: begin
            if (bus.m_ready) begin
               blk_d  = blk_q + 16'd1;
               beat_d = '0;
            end
         end
         default: ;
      endcase
   end

   // State and datapath registers; reset aborts any block in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FILL;
         beat_q  <= '0;
         buf_q   <= '0;
         acc_q   <= '0;
         k_q     <= '0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         buf_q   <= buf_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
         blk_q   <= blk_d;
      end
   end

   // While reset is held the bank stays in reset and every handshake is idle.
   assign gen_reset    = gen_reset_c | reset;
   assign busy         = busy_c & ~reset;
   assign bus.s_ready  = s_ready_c & ~reset;
   assign bus.seed_gnt = gnt_c & ~reset;
   assign bus.m_valid  = m_valid_c & ~reset;
   assign bus.m_data   = reset ? '0 : acc_q;
   assign blk_cnt      = blk_q;
endmodule

// File: tb/tb_toeplitz_seq.sv
// Directed/random bench for toeplitz_seq with a behavioural generator bank
// and a Toeplitz matrix-vector reference feeding a scoreboard queue.
module tb_toeplitz_seq;
   localparam int N = 16, L = 8, S = 2, W = 8;
   localparam int NB = N / W;
   localparam int DW = L + N - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          gen_reset;
   logic [S*L-1:0] gen_col;
   logic          busy;
   logic [15:0]   blk_cnt;

   toeplitz_seq_if #(.W(W), .L(L)) bus ();

   toeplitz_seq #(.N(N), .L(L), .STRIDE(S), .W(W)) dut (
      .clk(clk), .reset(reset), .bus(bus), .gen_reset(gen_reset),
      .gen_col(gen_col), .busy(busy), .blk_cnt(blk_cnt)
   );

   always #5 clk = ~clk;

   // Toeplitz matrix from a diagonal vector d: T[r][j] = d[r-j+N-1].
   // Column 0 is d[N-1 +: L] (col0); row 0 is d[N-1:0] reversed (rrow0).
   logic [DW-1:0] seed_cur;
   logic [DW-1:0] diag_q;
   int            kc;

   // Generator bank model: loads the seed on gen_reset, then emits column
   // kc*S+i on instance i, advancing one step per cycle.
   always @(posedge clk) begin
      if (gen_reset) begin
         diag_q <= seed_cur;
         kc     <= 0;
      end else begin
         kc <= kc + 1;
      end
   end

   always_comb begin
      gen_col = '0;
      for (int i = 0; i < S; i++) begin
         int j;
         j = kc * S + i;
         if (j < N)
            for (int r = 0; r < L; r++) gen_col[i*L + r] = diag_q[r - j + N - 1];
      end
   end

   function automatic logic [L-1:0] ref_hash(input logic [N-1:0] x, input logic [DW-1:0] d);
      logic [L-1:0] h;
      h = '0;
      for (int r = 0; r < L; r++)
         for (int j = 0; j < N; j++)
            h[r] = h[r] ^ (x[j] & d[r - j + N - 1]);
      return h;
   endfunction

   int n_assert = 0;
   int n_fail   = 0;
   int exp_blk  = 0;
   logic [L-1:0] exp_q[$];
   logic [L-1:0] obs_hist[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every output handshake pops one expected hash.
   always @(negedge clk) begin
      if (!reset && bus.m_valid && bus.m_ready) begin
         chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) chk("hash", 64'(bus.m_data), 64'(exp_q.pop_front()));
         obs_hist.push_back(bus.m_data);
      end
   end

   task automatic send_beat(input logic [W-1:0] d);
      int   t;
      logic took;
      bus.s_data  = d;
      bus.s_valid = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         took = bus.s_ready;
         @(posedge clk); #1;
         t++;
      end while (!took && t < 200);
      if (!took) chk("beat_timeout", 64'(took), 64'd1);
      bus.s_valid = 1'b0;
   endtask

   task automatic send_block(input logic [N-1:0] x);
      exp_q.push_back(ref_hash(x, seed_cur));
      exp_blk++;
      for (int b = 0; b < NB; b++) send_beat(x[b*W +: W]);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
      chk("blk_cnt", 64'(blk_cnt), 64'(exp_blk));
   endtask

   initial begin
      int            cyc, pulses, gseen;
      logic [L-1:0]  held;
      logic [N-1:0]  a, b, x;

      reset        = 1'b1;
      bus.s_data   = '0;
      bus.s_valid  = 1'b0;
      bus.m_ready  = 1'b1;
      bus.seed_req = 1'b0;
      seed_cur     = 23'h5A3C96;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      bus.s_valid = 1'b1;
      @(negedge clk);
      chk("rst_gen_reset", 64'(gen_reset), 64'd1);
      chk("rst_s_ready",   64'(bus.s_ready), 64'd0);
      chk("rst_m_valid",   64'(bus.m_valid), 64'd0);
      chk("rst_busy",      64'(busy), 64'd0);
      chk("rst_m_data",    64'(bus.m_data), 64'd0);
      chk("rst_blk_cnt",   64'(blk_cnt), 64'd0);
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("idle_s_ready",   64'(bus.s_ready), 64'd1);
      chk("idle_gen_reset", 64'(gen_reset), 64'd0);
      @(posedge clk); #1;

      // All-zero block: one gen_reset pulse, m_valid 10 cycles after last beat
      send_block('0);
      cyc = 0; pulses = 0;
      do begin
         @(negedge clk);
         cyc++;
         pulses += int'(gen_reset);
      end while (!bus.m_valid && cyc < 50);
      chk("zero_latency", 64'(cyc), 64'd10);
      chk("zero_pulses",  64'(pulses), 64'd1);
      drain();

      // Single-bit blocks select exactly one column each
      for (int j = 0; j < N; j++) begin
         x = '0;
         x[j] = 1'b1;
         send_block(x);
      end
      drain();

      // Linearity of the hash over GF(2)
      a = 16'hB37E; b = 16'h4C91;
      obs_hist.delete();
      send_block(a); send_block(b); send_block(a ^ b);
      drain();
      chk("lin_count", 64'(obs_hist.size()), 64'd3);
      chk("linear", 64'(obs_hist[2]), 64'(obs_hist[0] ^ obs_hist[1]));

      // Random blocks back to back
      for (int n = 0; n < 200; n++) send_block(N'($urandom));
      drain();

      // Output backpressure: held result, no beats taken, count only on handshake
      bus.m_ready = 1'b0;
      send_block(16'hE1D7);
      cyc = 0;
      while (!bus.m_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("bp_reached", 64'(bus.m_valid), 64'd1);
      held = ref_hash(16'hE1D7, seed_cur);
      @(posedge clk); #1;
      bus.s_data = 8'h3C; bus.s_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("bp_m_valid", 64'(bus.m_valid), 64'd1);
         chk("bp_m_data",  64'(bus.m_data), 64'(held));
         chk("bp_s_ready", 64'(bus.s_ready), 64'd0);
      end
      chk("bp_blk_hold", 64'(blk_cnt), 64'(exp_blk - 1));
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_blk_inc",  64'(blk_cnt), 64'(exp_blk));
      chk("bp_m_valid0", 64'(bus.m_valid), 64'd0);
      @(posedge clk); #1;

      // Seed request at beat 0 wins over data; beat taken next cycle
      bus.seed_req = 1'b1;
      bus.s_data = 8'h96; bus.s_valid = 1'b1;
      @(negedge clk);
      chk("seed_gnt0",    64'(bus.seed_gnt), 64'd1);
      chk("seed_s_ready", 64'(bus.s_ready), 64'd0);
      @(posedge clk); #1;
      seed_cur = 23'h1F0E3B;
      bus.seed_req = 1'b0;
      exp_q.push_back(ref_hash(16'h2D96, seed_cur));
      exp_blk++;
      @(negedge clk);
      chk("seed_then_beat", 64'(bus.s_ready), 64'd1);
      @(posedge clk); #1;
      send_beat(8'h2D);
      drain();

      // Seed request at beat 1 waits until the block is handed off
      bus.m_ready = 1'b0;
      exp_q.push_back(ref_hash(16'h7781, seed_cur));
      exp_blk++;
      send_beat(8'h81);
      bus.seed_req = 1'b1;
      send_beat(8'h77);
      gseen = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         gseen += int'(bus.seed_gnt);
      end
      chk("seed_wait_nogrant", 64'(gseen), 64'd0);
      @(posedge clk); #1;
      bus.m_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("seed_late_gnt", 64'(bus.seed_gnt), 64'd1);
      @(posedge clk); #1;
      seed_cur = 23'h6B2D44;
      bus.seed_req = 1'b0;
      drain();
      send_block(16'hC0DE);
      drain();

      // Reset in the middle of RUN aborts the block
      send_beat(8'h11);
      send_beat(8'h22);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_gen_reset", 64'(gen_reset), 64'd1);
      chk("mid_rst_m_valid",   64'(bus.m_valid), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      exp_blk = 0;
      @(negedge clk);
      chk("post_rst_busy",      64'(busy), 64'd0);
      chk("post_rst_m_valid",   64'(bus.m_valid), 64'd0);
      chk("post_rst_blk_cnt",   64'(blk_cnt), 64'd0);
      chk("post_rst_gen_reset", 64'(gen_reset), 64'd0);
      chk("post_rst_s_ready",   64'(bus.s_ready), 64'd1);
      @(posedge clk); #1;

      // Partial block lost to reset, then a clean block
      send_beat(8'hFF);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      send_block(16'h5AA5);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
